// File: rtl/dado_pkg.sv
// Shared types and constants for the die-roll generator.
package dado_pkg;

  typedef logic [2:0] cara_t;

  localparam cara_t CARA_MIN = 3'd1;
  localparam cara_t CARA_MAX = 3'd6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROLL  = 2'd1,
    OFFER = 2'd2
  } estado_t;

  // Next face in the 1..6 cycle; anything out of range recovers to 1.
  function automatic cara_t cara_siguiente(input cara_t c);
    if (c >= CARA_MAX || c < CARA_MIN) return CARA_MIN;
    return c + cara_t'(1);
  endfunction

endpackage

// File: rtl/antirrebote.sv
// Two-flop synchroniser followed by a counter-based debouncer for the push button.
module antirrebote #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic btn_i,
  output logic btn_o
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic             sync_q;
  logic             btn_s;
  logic [CNT_W-1:0] cnt_q;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q <= 1'b0;
      btn_s  <= 1'b0;
    end else begin
      sync_q <= btn_i;
      btn_s  <= sync_q;
    end
  end

  // Toggle the debounced level only after a sustained disagreement.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      btn_o <= 1'b0;
      cnt_q <= '0;
    end else if (btn_s == btn_o) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      btn_o <= btn_s;
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/dado_lanzador.sv
// Die-roll generator: debounced button spins a 1..6 face, release freezes
// and offers it over valid/ready.
// Optional build macro DADO_ROLL_COUNT_EN adds roll_count_o, a saturating
// count of accepted transfers.
module dado_lanzador
  import dado_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       btn_i,
  input  logic       ready_i,
  output logic       valid_o,
  output logic [2:0] data_o,
  output logic       rolling_o
`ifdef DADO_ROLL_COUNT_EN
  ,
  output logic [7:0] roll_count_o
`endif
);

  estado_t state_q;
  estado_t state_n;
  cara_t   face_n;
  logic    rolling_n;
  logic    valid_n;
  logic    btn_db;
  logic    btn_db_q;
  logic    rise;
  logic    fall;
  logic    accept;

  antirrebote #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_antirrebote (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .btn_i  (btn_i),
    .btn_o  (btn_db)
  );

  // Delayed debounced level for edge detection.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) btn_db_q <= 1'b0;
    else          btn_db_q <= btn_db;
  end

  assign rise   = btn_db & ~btn_db_q;
  assign fall   = ~btn_db & btn_db_q;
  assign accept = valid_o & ready_i;

  // State, face and registered outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      data_o    <= CARA_MIN;
      rolling_o <= 1'b0;
      valid_o   <= 1'b0;
    end else begin
      state_q   <= state_n;
      data_o    <= face_n;
      rolling_o <= rolling_n;
      valid_o   <= valid_n;
    end
  end

  // Next state; the face spins on every edge that lands in ROLL.
  always_comb begin
    state_n   = state_q;
    face_n    = data_o;
    rolling_n = 1'b0;
    valid_n   = 1'b0;
    case (state_q)
      IDLE:    if (rise)   state_n = ROLL;
      ROLL:    if (fall)   state_n = OFFER;
      OFFER:   if (accept) state_n = IDLE;
      default:             state_n = IDLE;
    endcase
    if (state_n == ROLL) face_n = cara_siguiente(data_o);
    if (data_o < CARA_MIN || data_o > CARA_MAX) face_n = CARA_MIN;
    rolling_n = (state_n == ROLL);
    valid_n   = (state_n == OFFER);
  end

`ifdef DADO_ROLL_COUNT_EN
  // Saturating count of faces taken by the downstream register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                            roll_count_o <= 8'd0;
    else if (accept && roll_count_o != 8'hFF) roll_count_o <= roll_count_o + 8'd1;
  end
`else
  // Transfer counter not built in this configuration.
`endif

endmodule

// File: tb/tb_dado_lanzador.sv
// Directed bench for dado_lanzador (DEBOUNCE_CYCLES=4).
module tb_dado_lanzador;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       btn = 1'b0;
  logic       ready = 1'b0;
  logic       valid;
  logic [2:0] data;
  logic       rolling;
`ifdef DADO_ROLL_COUNT_EN
  logic [7:0] roll_count;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int cnt_model = 0;

  always #5 clk = ~clk;

  dado_lanzador #(.DEBOUNCE_CYCLES(4)) dut (
    .clk_i    (clk),
    .rst_n_i  (rst_n),
    .btn_i    (btn),
    .ready_i  (ready),
    .valid_o  (valid),
    .data_o   (data),
    .rolling_o(rolling)
`ifdef DADO_ROLL_COUNT_EN
    ,
    .roll_count_o(roll_count)
`endif
  );

  typedef struct {
    int   press;     // clocks the button is held
    int   wait_rdy;  // OFFER cycles with ready low; 0 = ready held high throughout
    bit   rolled;    // a roll/offer is expected
    int   face;      // expected face afterwards
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_count(input string name);
`ifdef DADO_ROLL_COUNT_EN
    check(name, int'(roll_count), cnt_model);
`else
    if (name.len() < 0) $display("unreachable");
`endif
  endtask

  // Wait up to 40 cycles for valid; reports whether it appeared.
  task automatic wait_valid(output bit got, inout bit seen_roll);
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rolling) seen_roll = 1'b1;
      if (valid) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    bit got;
    bit seen_roll;
    bit held_ok;
    seen_roll = 1'b0;
    ready = (v.wait_rdy == 0);
    btn = 1'b1;
    for (int i = 0; i < v.press; i++) begin
      @(negedge clk);
      if (rolling) seen_roll = 1'b1;
    end
    btn = 1'b0;
    wait_valid(got, seen_roll);
    check($sformatf("vec%0d_rolled", idx), int'(seen_roll), int'(v.rolled));
    check($sformatf("vec%0d_valid", idx), int'(got), int'(v.rolled));
    check($sformatf("vec%0d_face", idx), int'(data), v.face);
    if (got) begin
      if (v.wait_rdy > 0) begin
        held_ok = 1'b1;
        for (int i = 0; i < v.wait_rdy; i++) begin
          @(negedge clk);
          if (!valid || data !== 3'(v.face)) held_ok = 1'b0;
        end
        check($sformatf("vec%0d_hold", idx), int'(held_ok), 1);
        ready = 1'b1;
      end
      @(negedge clk);
      cnt_model++;
      check($sformatf("vec%0d_drop", idx), int'(valid), 0);
      check_count($sformatf("vec%0d_count", idx));
    end
    ready = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  vec_t vecs[6];

  initial begin
    bit got;
    bit seen;
    bit ok;
    int lat;
    int n;

    vecs[0] = '{press: 20, wait_rdy: 1,  rolled: 1'b1, face: 3};
    vecs[1] = '{press: 3,  wait_rdy: 1,  rolled: 1'b0, face: 3};
    vecs[2] = '{press: 5,  wait_rdy: 2,  rolled: 1'b1, face: 2};
    vecs[3] = '{press: 6,  wait_rdy: 1,  rolled: 1'b1, face: 2};
    vecs[4] = '{press: 10, wait_rdy: 20, rolled: 1'b1, face: 6};
    vecs[5] = '{press: 4,  wait_rdy: 0,  rolled: 1'b1, face: 4};

    // Power-on reset, checked before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("por_data", int'(data), 1);
    check("por_valid", int'(valid), 0);
    check("por_rolling", int'(rolling), 0);
    check_count("por_count");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // Wrap from face 1: five steps reach 6, a full six steps come back to 6.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cnt_model = 0;
    @(negedge clk);
    run_vec(10, '{press: 5, wait_rdy: 1, rolled: 1'b1, face: 6});
    run_vec(11, '{press: 6, wait_rdy: 1, rolled: 1'b1, face: 6});

    // Press during OFFER is lost; a press still held at accept starts nothing.
    seen = 1'b0;
    btn = 1'b1;
    repeat (7) @(negedge clk);
    btn = 1'b0;
    wait_valid(got, seen);
    check("bp_valid", int'(got), 1);
    check("bp_face", int'(data), 1);
    ok = 1'b1;
    btn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 8) btn = 1'b0;
      if (!valid || data !== 3'd1 || rolling) ok = 1'b0;
    end
    check("bp_offer_stable", int'(ok), 1);
    btn = 1'b1;
    repeat (10) @(negedge clk);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    cnt_model++;
    check("bp_accept_drop", int'(valid), 0);
    check_count("bp_count");
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rolling || valid) ok = 1'b0;
    end
    check("held_no_roll", int'(ok), 1);
    check("held_face", int'(data), 1);
    btn = 1'b0;
    repeat (10) @(negedge clk);

    // Reset mid-roll, then a held button rolls again once debounced.
    btn = 1'b1;
    repeat (10) @(negedge clk);
    check("mid_rolling", int'(rolling), 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_data", int'(data), 1);
    check("mid_rst_valid", int'(valid), 0);
    check("mid_rst_rolling", int'(rolling), 0);
    cnt_model = 0;
    check_count("mid_rst_count");
    @(negedge clk);
    rst_n = 1'b1;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (rolling) begin
        lat = i;
        break;
      end
    end
    check("roll_latency", lat, 7);
    n = (lat != 0) ? 1 : 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rolling) n++;
    end
    btn = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (valid) begin
        got = 1'b1;
        break;
      end
      if (rolling) n++;
    end
    check("fresh_valid", int'(got), 1);
    check("fresh_n", n, 12);
    check("fresh_face", int'(data), (n % 6) + 1);
    check_count("fresh_count_pre");
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    cnt_model++;
    check("fresh_drop", int'(valid), 0);
    check_count("fresh_count_post");
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
